// File: rtl/dmem_responder.sv
// Word-organised data memory behind a valid/ready load/store port with a fixed,
// parameterised number of wait states between request accept and response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic access_err(input logic we, input logic [31:0] addr,
                                      input logic [2:0] size);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = addr[0];
      SZ_W:    err = (addr[1:0] != 2'b00);
      SZ_BU:   err = we;
      SZ_HU:   err = we | addr[0];
      default: err = 1'b1;
    endcase
    err = err | ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    return err;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0] lo,
                                               input logic [2:0] size);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {lo, 3'b000};
    b = shifted[7:0];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return {{24{b[7]}}, b};
      SZ_H:    return {{16{h[15]}}, h};
      SZ_W:    return word;
      SZ_BU:   return {24'd0, b};
      SZ_HU:   return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lo, input logic [2:0] size);
    case (size[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] size);
    case (size[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic          acc_we_s;
  logic [31:0]   acc_addr_s;
  logic [2:0]    acc_size_s;
  logic [31:0]   acc_wdata_s;
  logic [AW-1:0] idx_s;
  logic          err_s;
  logic          commit_s;
  logic          mem_we_s;
  logic [3:0]    be_s;
  logic [31:0]   wd_s;
  logic [31:0]   rd_word_s;

  // With zero wait states the commit edge is the accept edge, so the access
  // must come straight from the request port rather than the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_size_s  = req_size;
      acc_wdata_s = req_wdata;
    end else begin
      acc_we_s    = we_q;
      acc_addr_s  = addr_q;
      acc_size_s  = size_q;
      acc_wdata_s = wdata_q;
    end
    idx_s     = acc_addr_s[AW+1:2];
    err_s     = access_err(acc_we_s, acc_addr_s, acc_size_s);
    be_s      = store_be(acc_addr_s[1:0], acc_size_s);
    wd_s      = store_lanes(acc_wdata_s, acc_size_s);
    rd_word_s = mem[idx_s];
  end

  // Next-state, request capture and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    commit_s = (state_d == RESP) && (state_q != RESP);
    if (commit_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_s;
      rsp_rdata_d = (acc_we_s || err_s) ? 32'd0
                                        : load_extract(rd_word_s, acc_addr_s[1:0], acc_size_s);
    end else begin
      rsp_err_d = rsp_err_d;
    end
    mem_we_s = commit_s && acc_we_s && !err_s && !reset;
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      size_q      <= 3'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enabled storage write; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
